// File: rtl/riscv_m_unit_param_if.sv
// PCPI bus between the core and the M-extension co-processor.
interface riscv_m_unit_param_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic [31:0]     instruction;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            wr;
    logic [XLEN-1:0] rd;
    logic            busy;
    logic            ready;

    // Core side issues instructions and collects results.
    modport master (
        output valid, instruction, rs1, rs2,
        input  wr, rd, busy, ready
    );

    // Co-processor side.
    modport slave (
        input  valid, instruction, rs1, rs2,
        output wr, rd, busy, ready
    );
endinterface

// File: rtl/riscv_m_unit_param.sv
// RV32M/RV64M PCPI co-processor: pipelined multiplier, iterative restoring
// divider, divide-by-zero / signed-overflow fast paths and a DIV/REM pair cache.
module riscv_m_unit_param #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned MUL_STAGES       = 2,
    parameter int unsigned DIV_RADIX_LOG2   = 1,
    parameter int unsigned ENABLE_DIV_CACHE = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    riscv_m_unit_param_if.slave   bus
);

    localparam int unsigned DIV_ITERS = XLEN / DIV_RADIX_LOG2;
    localparam int unsigned CNT_W     = $clog2(XLEN + 1);
    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  F7_M      = 7'b0000001;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_PREP, S_DIV_ITER, S_DIV_FIX, S_DONE, S_GUARD
    } state_t;

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   a_q, b_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   quo, rem, dvs;
    logic              neg_q, neg_r;
    logic              busy_q, ready_q, wr_q;
    logic [XLEN-1:0]   rd_q;

    logic              c_vld, c_sgn;
    logic [XLEN-1:0]   c_a, c_b, c_q, c_r;

    logic [2*XLEN-1:0] pipe [MUL_STAGES];

    logic              dec_c;
    logic              div_sgn_c, a_neg_c, b_neg_c, ovf_c, hit_c;
    logic [XLEN-1:0]   abs_a_c, abs_b_c;
    logic [XLEN-1:0]   quo_nxt, rem_nxt, q_fix_c, r_fix_c;
    logic [XLEN:0]     step_t;
    logic              mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] ma, mb, prod_c;
    logic [XLEN-1:0]   mul_res_c;

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.wr    = wr_q;
    assign bus.rd    = rd_q;

    // Instruction decode: R-type OP with the M-extension funct7.
    always_comb begin
        dec_c = (bus.instruction[6:0] == OPC_OP) && (bus.instruction[31:25] == F7_M);
    end

    // Divider operand conditioning, fast-path and cache-hit detection.
    always_comb begin
        div_sgn_c = ~op[0];
        a_neg_c   = div_sgn_c & a_q[XLEN-1];
        b_neg_c   = div_sgn_c & b_q[XLEN-1];
        abs_a_c   = a_neg_c ? -a_q : a_q;
        abs_b_c   = b_neg_c ? -b_q : b_q;
        ovf_c     = div_sgn_c && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        hit_c     = (ENABLE_DIV_CACHE != 0) && c_vld && (c_a == a_q) && (c_b == b_q)
                    && (c_sgn == div_sgn_c);
        q_fix_c   = neg_q ? -quo : quo;
        r_fix_c   = neg_r ? -rem : rem;
    end

    // Restoring division: DIV_RADIX_LOG2 quotient bits per clock.
    always_comb begin
        rem_nxt = rem;
        quo_nxt = quo;
        step_t  = '0;
        for (int unsigned k = 0; k < DIV_RADIX_LOG2; k++) begin
            step_t  = {rem_nxt, quo_nxt[XLEN-1]};
            quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            if (step_t >= {1'b0, dvs}) begin
                step_t     = step_t - {1'b0, dvs};
                quo_nxt[0] = 1'b1;
            end
            rem_nxt = step_t[XLEN-1:0];
        end
    end

    // Multiplier operand extension and result half selection.
    always_comb begin
        mul_a_sgn = op[0] ^ op[1];
        mul_b_sgn = (op[1:0] == 2'b01);
        ma        = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
        mb        = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
        prod_c    = ma * mb;
        mul_res_c = (op[1:0] == 2'b00) ? pipe[MUL_STAGES-1][XLEN-1:0]
                                       : pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
    end

    // Multiplier pipeline; operands are held stable while in MUL.
    always_ff @(posedge clk) begin
        pipe[0] <= prod_c;
        for (int unsigned i = 1; i < MUL_STAGES; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    // Control FSM with registered bus outputs and the result cache.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            op      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
            c_vld   <= 1'b0;
            c_sgn   <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_q     <= '0;
            c_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid && dec_c) begin
                        op     <= bus.instruction[14:12];
                        a_q    <= bus.rs1;
                        b_q    <= bus.rs2;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= bus.instruction[14] ? S_DIV_PREP : S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt == CNT_W'(MUL_STAGES)) begin
                        rd_q    <= mul_res_c;
                        ready_q <= 1'b1;
                        wr_q    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV_PREP: begin
                    cnt   <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    if (hit_c) begin
                        quo   <= c_q;
                        rem   <= c_r;
                        state <= S_DIV_FIX;
                    end else if (b_q == '0) begin
                        quo   <= '1;
                        rem   <= a_q;
                        state <= S_DIV_FIX;
                    end else if (ovf_c) begin
                        quo   <= a_q;
                        rem   <= '0;
                        state <= S_DIV_FIX;
                    end else begin
                        quo   <= abs_a_c;
                        rem   <= '0;
                        dvs   <= abs_b_c;
                        neg_q <= a_neg_c ^ b_neg_c;
                        neg_r <= a_neg_c;
                        state <= S_DIV_ITER;
                    end
                end
                S_DIV_ITER: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                        state <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    rd_q    <= op[1] ? r_fix_c : q_fix_c;
                    ready_q <= 1'b1;
                    wr_q    <= 1'b1;
                    state   <= S_DONE;
                    if (ENABLE_DIV_CACHE != 0) begin
                        c_vld <= 1'b1;
                        c_sgn <= div_sgn_c;
                        c_a   <= a_q;
                        c_b   <= b_q;
                        c_q   <= q_fix_c;
                        c_r   <= r_fix_c;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    wr_q    <= 1'b0;
                    rd_q    <= '0;
                    busy_q  <= 1'b0;
                    state   <= S_GUARD;
                end
                S_GUARD: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_m_unit_param.sv
// Scoreboard bench for riscv_m_unit_param: two configurations driven by
// directed and random PCPI transactions, checked against an arithmetic model.
module tb_riscv_m_unit_param;

    localparam int unsigned MS0 = 2, RL0 = 1, CE0 = 1;
    localparam int unsigned MS1 = 3, RL1 = 2, CE1 = 0;

    typedef struct {
        logic [31:0] rd;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    riscv_m_unit_param_if #(.XLEN(32)) bus0 ();
    riscv_m_unit_param_if #(.XLEN(32)) bus1 ();

    riscv_m_unit_param #(.XLEN(32), .MUL_STAGES(MS0), .DIV_RADIX_LOG2(RL0),
                         .ENABLE_DIV_CACHE(CE0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(bus0));
    riscv_m_unit_param #(.XLEN(32), .MUL_STAGES(MS1), .DIV_RADIX_LOG2(RL1),
                         .ENABLE_DIV_CACHE(CE1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1));

    logic        vld [2];
    logic [31:0] ins [2];
    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic        rdy [2];
    logic        wrs [2];
    logic        bsy [2];
    logic [31:0] rdo [2];

    assign bus0.valid = vld[0];  assign bus0.instruction = ins[0];
    assign bus0.rs1   = op1[0];  assign bus0.rs2         = op2[0];
    assign bus1.valid = vld[1];  assign bus1.instruction = ins[1];
    assign bus1.rs1   = op1[1];  assign bus1.rs2         = op2[1];
    assign rdy[0] = bus0.ready;  assign wrs[0] = bus0.wr;
    assign bsy[0] = bus0.busy;   assign rdo[0] = bus0.rd;
    assign rdy[1] = bus1.ready;  assign wrs[1] = bus1.wr;
    assign bsy[1] = bus1.busy;   assign rdo[1] = bus1.rd;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   next_ok [2];
    bit          cvld [2];
    bit          cs   [2];
    logic [31:0] ca   [2];
    logic [31:0] cb   [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mk_ins(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Monitor: every ready pops one expectation; otherwise rd and wr must be 0.
    always @(negedge clk) begin
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                if (rdy[d]) begin
                    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                        check($sformatf("unexpected_ready_dut%0d", d), 64'd1, 64'd0);
                    end else begin
                        if (d == 0) mon_e = sb0.pop_front();
                        else        mon_e = sb1.pop_front();
                        check($sformatf("rd_dut%0d", d), 64'(rdo[d]), 64'(mon_e.rd));
                        check($sformatf("wr_dut%0d", d), 64'(wrs[d]), 64'd1);
                        check($sformatf("latency_dut%0d", d), 64'(cyc - mon_e.acc),
                              64'(mon_e.lat));
                    end
                end else begin
                    check($sformatf("idle_rd_wr_dut%0d", d), {31'd0, wrs[d], rdo[d]}, 64'd0);
                end
            end
        end
    end

    // Issue one instruction, push the model's answer, wait for completion.
    task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit early, input bit drop,
                         output logic [31:0] got, output int lat);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] q, r;
        longint      sa, sbv, ua, ub;
        bit          sg, bz, ov, hit, done;
        int          ms, rl, ce;
        ms = (d == 0) ? MS0 : MS1;
        rl = (d == 0) ? RL0 : RL1;
        ce = (d == 0) ? CE0 : CE1;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        if (!f3[2]) begin
            case (f3[1:0])
                2'd0: p = ua * ub;
                2'd1: p = sa * sbv;
                2'd2: p = sa * ub;
                default: p = ua * ub;
            endcase
            e.rd  = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
            e.lat = ms + 1;
        end else begin
            sg  = !f3[0];
            bz  = (b == 32'h0);
            ov  = sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
            hit = (ce != 0) && cvld[d] && ca[d] == a && cb[d] == b && cs[d] == sg;
            if (bz) begin
                q = 32'hFFFF_FFFF; r = a;
            end else if (ov) begin
                q = a; r = 32'h0;
            end else if (sg) begin
                q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            end else begin
                q = a / b; r = a % b;
            end
            e.rd  = f3[1] ? r : q;
            e.lat = (hit || bz || ov) ? 2 : (32 / rl + 2);
            cvld[d] = (ce != 0); ca[d] = a; cb[d] = b; cs[d] = sg;
        end
        while (cyc + 1 < next_ok[d] - (early ? 1 : 0)) @(negedge clk);
        vld[d] = 1'b1;
        ins[d] = mk_ins(7'b0000001, f3, 7'b0110011);
        op1[d] = a;
        op2[d] = b;
        e.acc = (cyc + 1 > next_ok[d]) ? cyc + 1 : next_ok[d];
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        got = '0; lat = -1; done = 1'b0;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (cyc == e.acc) begin
                check("busy_after_accept", 64'(bsy[d]), 64'd1);
                if (drop) vld[d] = 1'b0;
            end
            if (rdy[d]) done = 1'b1;
        end
        vld[d] = 1'b0;
        if (!done) begin
            check($sformatf("timeout_dut%0d", d), 64'd0, 64'd1);
            if (d == 0) void'(sb0.pop_back());
            else        void'(sb1.pop_back());
            next_ok[d] = cyc + 1;
        end else begin
            got = rdo[d];
            lat = cyc - e.acc;
            check("busy_at_ready", 64'(bsy[d]), 64'd1);
            next_ok[d] = cyc + 3;
            @(negedge clk);
            check("outputs_after_done", {61'd0, bsy[d], rdy[d], wrs[d]}, 64'd0);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] got;
    int          lat;
    int          acc;
    logic [31:0] la [2];
    logic [31:0] lb [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0; ins[d] = '0; op1[d] = '0; op2[d] = '0;
            cvld[d] = 1'b0; cs[d] = 1'b0; ca[d] = '0; cb[d] = '0;
            la[d] = 32'd1; lb[d] = 32'd1;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_outputs", {30'd0, bsy[d], rdy[d], wrs[d], rdo[d]}, 64'd0);
        end
        resetn = 1'b1;
        next_ok[0] = cyc + 1;
        next_ok[1] = cyc + 1;

        // Multiplies.
        issue(0, 3'd0, 32'hFFFF_FFFF, 32'h2, 0, 0, got, lat);
        check("plan_mul_rd", 64'(got), 64'hFFFF_FFFE);
        check("plan_mul_lat", 64'(lat), 64'd3);
        issue(0, 3'd1, 32'hFFFF_FFFF, 32'h2, 0, 0, got, lat);
        check("plan_mulh_rd", 64'(got), 64'hFFFF_FFFF);
        issue(0, 3'd3, 32'hFFFF_FFFF, 32'h2, 1, 0, got, lat);
        check("plan_mulhu_rd", 64'(got), 64'h1);

        // Divide, then cached remainder.
        issue(0, 3'd4, 32'hFFFF_FFF9, 32'h2, 0, 0, got, lat);
        check("plan_div_rd", 64'(got), 64'hFFFF_FFFD);
        check("plan_div_lat", 64'(lat), 64'd34);
        issue(0, 3'd6, 32'hFFFF_FFF9, 32'h2, 0, 0, got, lat);
        check("plan_rem_hit_rd", 64'(got), 64'hFFFF_FFFF);
        check("plan_rem_hit_lat", 64'(lat), 64'd2);

        // Divide by zero.
        issue(0, 3'd5, 32'd100, 32'h0, 0, 0, got, lat);
        check("plan_divu0_rd", 64'(got), 64'hFFFF_FFFF);
        check("plan_divu0_lat", 64'(lat), 64'd2);
        issue(0, 3'd7, 32'd5, 32'h0, 0, 0, got, lat);
        check("plan_remu0_rd", 64'(got), 64'd5);

        // Signed overflow.
        issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, got, lat);
        check("plan_ovf_div_rd", 64'(got), 64'h8000_0000);
        check("plan_ovf_div_lat", 64'(lat), 64'd2);
        issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, got, lat);
        check("plan_ovf_rem_rd", 64'(got), 64'h0);

        // Non-M instructions are ignored.
        while (cyc + 1 < next_ok[0]) @(negedge clk);
        vld[0] = 1'b1;
        ins[0] = mk_ins(7'b0000000, 3'd4, 7'b0110011);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nonm_quiet", {61'd0, bsy[0], rdy[0], wrs[0]}, 64'd0);
        end
        ins[0] = mk_ins(7'b0000001, 3'd0, 7'b0010011);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrong_opcode_quiet", {61'd0, bsy[0], rdy[0], wrs[0]}, 64'd0);
        end
        vld[0] = 1'b0;
        @(negedge clk);

        // Reset in the middle of a divide.
        while (cyc + 1 < next_ok[0]) @(negedge clk);
        vld[0] = 1'b1;
        ins[0] = mk_ins(7'b0000001, 3'd4, 7'b0110011);
        op1[0] = 32'd12345678;
        op2[0] = 32'd3;
        acc = cyc + 1;
        while (cyc < acc + 11) @(negedge clk);
        resetn = 1'b0;
        vld[0] = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", {30'd0, bsy[0], rdy[0], wrs[0], rdo[0]}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cvld[d] = 1'b0;
            next_ok[d] = cyc + 1;
        end
        repeat (40) @(negedge clk);
        issue(0, 3'd5, 32'd9, 32'd3, 0, 0, got, lat);
        check("plan_post_reset_rd", 64'(got), 64'd3);
        check("plan_post_reset_lat", 64'(lat), 64'd34);

        // Radix-4 configuration.
        issue(1, 3'd5, 32'd1000, 32'd7, 0, 0, got, lat);
        check("plan_radix4_rd", 64'(got), 64'd142);
        check("plan_radix4_lat", 64'(lat), 64'd18);

        // Random traffic on both configurations.
        for (int i = 0; i < 90; i++) begin
            int          d;
            logic [2:0]  f3;
            logic [31:0] a, b;
            d  = $urandom_range(0, 1);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                a = la[d]; b = lb[d];
            end else begin
                a = rnd_op(); b = rnd_op();
            end
            issue(d, f3, a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  got, lat);
            la[d] = a; lb[d] = b;
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
